// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor. Two WIDTH-bit operands are latched on start and
// consumed one bit per clock, LSB first, through a single full-adder cell made
// of two half-adder stages and a carry flop. Results appear with a done pulse.
module serial_addsub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    // Holds the WIDTH-1 low result bits; the MSB joins them on the final edge.
    logic [WIDTH-2:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             ha1_s, ha1_c, ha2_c;
    logic             fa_sum, fa_carry;
    logic [WIDTH-1:0] shifted;

    // Full-adder cell from two half-adder stages on the current LSBs.
    always_comb begin
        ha1_s    = opa_q[0] ^ opb_q[0];
        ha1_c    = opa_q[0] & opb_q[0];
        fa_sum   = ha1_s ^ carry_q;
        ha2_c    = ha1_s & carry_q;
        fa_carry = ha1_c | ha2_c;
        shifted  = {fa_sum, res_q};
    end

    // Next-state logic: accept, shift one bit per clock, publish on the last bit.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                if (start) begin
                    state_d = StRun;
                    opa_d   = a;
                    // Subtraction as a + ~b + 1: invert B, carry-in of one.
                    opb_d   = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            StRun: begin
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                carry_d = fa_carry;
                res_d   = shifted[WIDTH-1:1];
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sum_d   = shifted;
                    cout_d  = fa_carry;
                    // Carry into the MSB differs from carry out => signed overflow.
                    ovf_d   = carry_q ^ fa_carry;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised bit-serial adder/subtractor, the multi-bit successor of the team's combinational half adder.
- Latches two WIDTH-bit operands on a start pulse.
- Processes one bit per clock, LSB first, through a single full-adder cell built from two half-adder stages plus a carry flip-flop.
- Reports sum, carry-out and signed overflow with a done pulse.
- Used where area matters more than latency, e.g. accumulators and address arithmetic in the lab datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled high while not busy launches an operation
- sub  input  1  0 = a+b, 1 = a-b; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- sum  output  WIDTH  result; valid from done, held until next accepted start
- cout  output  1  carry-out (add) / no-borrow flag (sub: 1 = a>=b unsigned)
- ovf  output  1  signed two's-complement overflow
- busy  output  1  high while bits are being processed
- done  output  1  single-cycle pulse when results become valid

Behaviour:
- Reset (rst_n low, asynchronous):
  - sum=0, cout=0, ovf=0, busy=0, done=0.
  - FSM=IDLE; counter, carry and operand registers cleared.
  - Reset mid-operation aborts it; no done pulse follows.
- FSM states:
  - IDLE --start--> RUN.
  - RUN --count==WIDTH-1 at edge--> DONE.
  - DONE --next edge--> IDLE, or RUN if start is high in that cycle.
- Accept, at edge 0 (IDLE or DONE with start=1):
  - opA<=a; opB<=(sub ? ~b : b); carry<=sub; count<=0.
  - busy goes high after edge 0.
- RUN, each edge k=1..WIDTH processes bit i=k-1:
  - s_i = opA[0]^opB[0]^carry; carry <= majority(opA[0],opB[0],carry).
  - opA, opB shift right; s_i shifts into the MSB of the result shift register.
  - At i=WIDTH-1, capture the carry into the MSB as c_msb_in, and the new carry as cout.
- Completion:
  - After edge WIDTH: busy=0, done=1, and sum/cout/ovf are updated together.
  - ovf = c_msb_in ^ cout.
  - After edge WIDTH+1: done=0; outputs hold.
- Latency: exactly WIDTH+1 clocks from the accepting edge to the end of the done cycle. Throughput is one operation per WIDTH+1 clocks when start is held or pulsed in each done cycle.
- Ignored inputs:
  - start while busy=1 is ignored, with no queueing.
  - a, b and sub changes during RUN have no effect.
- sum/cout/ovf are not updated during RUN. They show the previous result until done.
- Counter width is clog2(WIDTH). Sub mode is two's-complement via inverted B and carry-in 1.

Test Plan:
- WIDTH=8, add 0x3C+0x45 -> done exactly 9 clocks after the start edge; sum=0x81, cout=0, ovf=1; busy high 8 cycles.
- WIDTH=8, add 0xFF+0x01 -> sum=0x00, cout=1, ovf=0. Then sub 0x10-0x20 -> sum=0xF0, cout=0, ovf=0.
- WIDTH=8, sub 0x80-0x01 -> sum=0x7F, cout=1, ovf=1. Toggle a/b/sub and pulse start during RUN -> result unchanged, no extra done.
- Assert rst_n low at the 4th RUN cycle, release -> all outputs 0, no done; a new start 0x01+0x01 -> sum=0x02 after 9 clocks.
- Hold start high continuously with new operands each done cycle -> back-to-back done pulses every 9 clocks, each result correct.
- WIDTH=2 exhaustive: all a,b,sub (32 cases) -> sum, cout, ovf match a golden model.
